// File: rtl/gcd_job_sequencer_if.sv
// Handshake and core-side bundle for gcd_job_sequencer.
// slave = sequencer view, master = producer/consumer/core view.
interface gcd_job_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_X;
    logic [WIDTH-1:0] IN_Y;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_GCD;
    logic             OUT_ERR;
    logic [WIDTH-1:0] GCD_X;
    logic [WIDTH-1:0] GCD_Y;
    logic             GCD_START;
    logic [WIDTH-1:0] GCD_RESULT;
    logic             GCD_DONE;
    logic             BUSY;
    logic [CW-1:0]    COUNT;

    modport slave (
        input  IN_VALID, IN_X, IN_Y, OUT_READY, GCD_RESULT, GCD_DONE,
        output IN_READY, OUT_VALID, OUT_GCD, OUT_ERR, GCD_X, GCD_Y,
               GCD_START, BUSY, COUNT
    );

    modport master (
        output IN_VALID, IN_X, IN_Y, OUT_READY, GCD_RESULT, GCD_DONE,
        input  IN_READY, OUT_VALID, OUT_GCD, OUT_ERR, GCD_X, GCD_Y,
               GCD_START, BUSY, COUNT
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs, runs the GCD core one job at a time and returns
// results in order; zero operands bypass the core, a watchdog aborts hung jobs.
module gcd_job_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET_N,
    gcd_job_sequencer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_rst_sync;
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic               r_guard;
    logic               w_guard_nxt;
    logic [WW-1:0]      r_wdog;
    logic [WW-1:0]      w_wdog_nxt;
    logic [WIDTH-1:0]   r_gcd_x;
    logic [WIDTH-1:0]   r_gcd_y;
    logic [WIDTH-1:0]   r_out_gcd;
    logic [WIDTH-1:0]   w_out_gcd_nxt;
    logic               r_out_err;
    logic               w_out_err_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_zero;
    logic               w_timeout;
    logic [WIDTH-1:0]   w_head_x;
    logic [WIDTH-1:0]   w_head_y;

    assign {w_head_x, w_head_y} = r_mem[r_rd_ptr];
    assign bus.IN_READY = (r_count != CW'(DEPTH));
    assign w_push       = bus.IN_VALID & bus.IN_READY;
    // Pops wait for the synchronised reset release
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0) && r_rst_sync[1];
    assign w_zero       = (w_head_x == '0) || (w_head_y == '0);
    assign w_timeout    = (r_wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_state_nxt = w_zero ? S_HOLD : S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_GUARD;
            S_GUARD:  if (r_guard) w_state_nxt = S_WAIT;
            S_WAIT:   if (bus.GCD_DONE || w_timeout) w_state_nxt = S_HOLD;
            S_HOLD:   if (bus.OUT_READY) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Outputs are registered, so this computes their next-cycle values
    always_comb begin
        w_start_nxt     = (w_state_nxt == S_LAUNCH);
        w_out_valid_nxt = (w_state_nxt == S_HOLD);
        w_busy_nxt      = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
        w_guard_nxt     = (r_state == S_GUARD) ? ~r_guard : 1'b0;
        w_wdog_nxt      = ((r_state == S_WAIT) && (w_state_nxt == S_WAIT))
                          ? r_wdog + WW'(1) : '0;
        w_out_gcd_nxt   = r_out_gcd;
        w_out_err_nxt   = r_out_err;
        case (r_state)
            S_IDLE: begin
                if (w_pop && w_zero) begin
                    w_out_gcd_nxt = w_head_x | w_head_y;
                    w_out_err_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.GCD_DONE) begin
                    w_out_gcd_nxt = bus.GCD_RESULT;
                    w_out_err_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_out_gcd_nxt = '0;
                    w_out_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.IN_X, bus.IN_Y};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_guard     <= 1'b0;
            r_wdog      <= '0;
            r_gcd_x     <= '0;
            r_gcd_y     <= '0;
            r_out_gcd   <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_guard     <= w_guard_nxt;
            r_wdog      <= w_wdog_nxt;
            r_out_gcd   <= w_out_gcd_nxt;
            r_out_err   <= w_out_err_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_start     <= w_start_nxt;
            r_busy      <= w_busy_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_gcd_x  <= w_head_x;
                r_gcd_y  <= w_head_y;
            end
        end
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_GCD   = r_out_gcd;
    assign bus.OUT_ERR   = r_out_err;
    assign bus.GCD_X     = r_gcd_x;
    assign bus.GCD_Y     = r_gcd_y;
    assign bus.GCD_START = r_start;
    assign bus.BUSY      = r_busy;
    assign bus.COUNT     = r_count;
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: behavioural GCD core, in-order scoreboard,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_gcd_job_sequencer;
    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    gcd_job_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    gcd_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int gcd;
        int err;
    } res_t;

    typedef struct {
        int x;
        int y;
        int exp_gcd;
        int exp_lat;
        int exp_starts;
    } vec_t;

    int   checks = 0;
    int   passes = 0;
    res_t exp_q[$];
    int   obs_q[$];
    int   start_cnt = 0;
    int   peak = 0;
    int   core_lat_fixed = 0;
    bit   core_stuck = 1'b0;
    int   core_stale = 0;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural core: DONE is a level that stays up until the next START;
    // core_stale keeps the previous DONE/result visible for a few cycles.
    initial begin : core_model
        int  res, jx, jy, countdown, stale_left;
        bit  pending, xy_bad;
        pending = 1'b0;
        stale_left = 0;
        countdown = 0;
        res = 0; jx = 0; jy = 0; xy_bad = 1'b0;
        bus.GCD_DONE = 1'b0;
        bus.GCD_RESULT = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET_N) begin
                bus.GCD_DONE = 1'b0;
                pending = 1'b0;
                stale_left = 0;
            end else if (bus.GCD_START) begin
                jx = int'(bus.GCD_X);
                jy = int'(bus.GCD_Y);
                res = ref_gcd(jx, jy);
                xy_bad = 1'b0;
                countdown = (core_lat_fixed > 0) ? core_lat_fixed : int'($urandom_range(1, 10));
                pending = !core_stuck;
                stale_left = core_stale;
                if (stale_left == 0) bus.GCD_DONE = 1'b0;
            end else begin
                if (pending && (int'(bus.GCD_X) != jx || int'(bus.GCD_Y) != jy)) xy_bad = 1'b1;
                if (stale_left > 0) begin
                    stale_left--;
                    if (stale_left == 0) bus.GCD_DONE = 1'b0;
                end else if (pending) begin
                    countdown--;
                    if (countdown == 0) begin
                        bus.GCD_DONE = 1'b1;
                        bus.GCD_RESULT = WIDTH'(res);
                        pending = 1'b0;
                        check("operands_stable", int'(xy_bad), 0);
                    end
                end
            end
        end
    end

    // Reference model and scoreboard: every accepted pair yields one result, in order
    always @(negedge CLK) begin
        res_t e;
        if (RESET_N) begin
            if (bus.GCD_START) start_cnt++;
            if (int'(bus.COUNT) > peak) peak = int'(bus.COUNT);
            if (bus.IN_VALID && bus.IN_READY) begin
                e.err = (core_stuck && bus.IN_X != '0 && bus.IN_Y != '0) ? 1 : 0;
                e.gcd = e.err ? 0 : ref_gcd(int'(bus.IN_X), int'(bus.IN_Y));
                exp_q.push_back(e);
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                obs_q.push_back(int'(bus.OUT_GCD));
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got result %0d, expected none", bus.OUT_GCD);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_gcd", int'(bus.OUT_GCD), e.gcd);
                    check("sb_err", int'(bus.OUT_ERR), e.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int x, input int y);
        int   n;
        logic rdy;
        n = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_X = WIDTH'(x);
        bus.IN_Y = WIDTH'(y);
        do begin
            rdy = bus.IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 200);
        bus.IN_VALID = 1'b0;
        if (!rdy) check("push_accepted", 0, 1);
    endtask

    task automatic wait_out(output int cyc, input int budget);
        cyc = 0;
        while (!bus.OUT_VALID && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (!bus.OUT_VALID) check("out_valid_arrived", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.BUSY || bus.OUT_VALID) && n < 1000) begin
            tick(1);
            n++;
        end
        if (bus.BUSY || bus.OUT_VALID) check("drained", 0, 1);
    endtask

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat, s0;
        int exp_seq[$];
        bit rnd_done;

        vecs[0] = '{12,  9,  3, 7, 1};
        vecs[1] = '{15,  4,  1, 7, 1};
        vecs[2] = '{ 8, 12,  4, 7, 1};
        vecs[3] = '{ 7,  7,  7, 7, 1};
        vecs[4] = '{ 0,  7,  7, 1, 0};
        vecs[5] = '{ 0,  0,  0, 1, 0};
        vecs[6] = '{ 9,  0,  9, 1, 0};
        vecs[7] = '{15, 15, 15, 7, 1};
        vecs[8] = '{ 1, 14,  1, 7, 1};
        vecs[9] = '{ 6, 10,  2, 7, 1};

        bus.IN_VALID = 1'b0;
        bus.IN_X = '0;
        bus.IN_Y = '0;
        bus.OUT_READY = 1'b1;

        tick(3);
        check("rst_count", int'(bus.COUNT), 0);
        check("rst_in_ready", int'(bus.IN_READY), 1);
        check("rst_out_valid", int'(bus.OUT_VALID), 0);
        check("rst_outs", int'({bus.OUT_GCD, bus.OUT_ERR, bus.GCD_X, bus.GCD_Y}), 0);
        check("rst_start_busy", int'({bus.GCD_START, bus.BUSY}), 0);
        RESET_N = 1'b1;
        tick(4);

        // Single job cycle-by-cycle
        core_lat_fixed = 5;
        s0 = start_cnt;
        push(12, 9);
        check("t_count_after_push", int'(bus.COUNT), 1);
        check("t_start_before", int'(bus.GCD_START), 0);
        tick(1);
        check("t_start_pulse", int'(bus.GCD_START), 1);
        check("t_gcd_x", int'(bus.GCD_X), 12);
        check("t_gcd_y", int'(bus.GCD_Y), 9);
        check("t_count_after_pop", int'(bus.COUNT), 0);
        tick(1);
        check("t_start_dropped", int'(bus.GCD_START), 0);
        check("t_busy", int'(bus.BUSY), 1);
        wait_out(lat, 100);
        check("t_latency", lat + 2, 7);
        check("t_out_gcd", int'(bus.OUT_GCD), 3);
        check("t_start_count", start_cnt - s0, 1);
        wait_idle();

        // Directed vectors, fixed core latency
        for (int i = 0; i < 10; i++) begin
            s0 = start_cnt;
            push(vecs[i].x, vecs[i].y);
            wait_out(lat, 100);
            check("vec_gcd", int'(bus.OUT_GCD), vecs[i].exp_gcd);
            check("vec_err", int'(bus.OUT_ERR), 0);
            check("vec_latency", lat, vecs[i].exp_lat);
            check("vec_operands", int'({bus.GCD_X, bus.GCD_Y}), (vecs[i].x << WIDTH) | vecs[i].y);
            check("vec_starts", start_cnt - s0, vecs[i].exp_starts);
        end
        wait_idle();

        // Back-to-back pushes
        core_lat_fixed = 0;
        peak = 0;
        s0 = start_cnt;
        obs_q.delete();
        push(12, 9);
        push(15, 4);
        push(8, 12);
        push(7, 7);
        wait_idle();
        exp_seq = '{3, 1, 4, 7};
        check("b2b_count", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) check("b2b_order", obs_q[i], exp_seq[i]);
        check("b2b_starts", start_cnt - s0, 4);
        check("b2b_peak", peak, 3);

        // Backpressure: result held, FIFO full, refuses input
        obs_q.delete();
        bus.OUT_READY = 1'b0;
        push(3, 6);
        push(10, 4);
        push(9, 6);
        push(14, 7);
        push(5, 3);
        tick(20);
        check("bp_in_ready", int'(bus.IN_READY), 0);
        check("bp_count", int'(bus.COUNT), 4);
        check("bp_out_valid", int'(bus.OUT_VALID), 1);
        check("bp_held_gcd", int'(bus.OUT_GCD), 3);
        bus.IN_VALID = 1'b1;
        bus.IN_X = 4'd8;
        bus.IN_Y = 4'd6;
        tick(5);
        bus.IN_VALID = 1'b0;
        check("bp_still_gcd", int'(bus.OUT_GCD), 3);
        check("bp_refused", exp_q.size(), 5);
        bus.OUT_READY = 1'b1;
        push(8, 6);
        wait_idle();
        exp_seq = '{3, 2, 3, 7, 1, 2};
        check("bp_drain_count", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) check("bp_order", obs_q[i], exp_seq[i]);

        // Watchdog abort, recovery, stale DONE masked by guard
        core_stuck = 1'b1;
        push(12, 9);
        wait_out(lat, 100);
        core_stuck = 1'b0;
        check("to_latency", lat, 4 + TIMEOUT);
        check("to_err", int'(bus.OUT_ERR), 1);
        check("to_gcd", int'(bus.OUT_GCD), 0);
        tick(1);
        push(15, 10);
        wait_out(lat, 100);
        check("to_next_gcd", int'(bus.OUT_GCD), 5);
        check("to_next_err", int'(bus.OUT_ERR), 0);
        tick(1);
        core_stale = 3;
        push(8, 12);
        wait_out(lat, 100);
        check("stale_masked", int'(bus.OUT_GCD), 4);
        core_stale = 0;
        wait_idle();

        // Random traffic against the reference model
        obs_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 2));
                    push($urandom_range(0, 15), $urandom_range(0, 15));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1;
                    bus.OUT_READY = $urandom_range(0, 1);
                end
            end
        join
        bus.OUT_READY = 1'b1;
        wait_idle();
        check("rnd_all_out", obs_q.size(), 40);
        check("rnd_sb_empty", exp_q.size(), 0);

        // Reset during WAIT with two jobs queued
        core_stuck = 1'b1;
        push(12, 9);
        push(15, 4);
        push(8, 12);
        tick(8);
        check("mr_count_before", int'(bus.COUNT), 2);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mr_count", int'(bus.COUNT), 0);
        check("mr_in_ready", int'(bus.IN_READY), 1);
        check("mr_out_valid", int'(bus.OUT_VALID), 0);
        check("mr_outs", int'({bus.OUT_GCD, bus.OUT_ERR, bus.GCD_X, bus.GCD_Y}), 0);
        check("mr_start_busy", int'({bus.GCD_START, bus.BUSY}), 0);
        exp_q.delete();
        s0 = obs_q.size();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        core_stuck = 1'b0;
        tick(30);
        check("mr_no_result", obs_q.size(), s0);
        check("mr_count_after", int'(bus.COUNT), 0);
        check("mr_busy_after", int'(bus.BUSY), 0);
        push(9, 6);
        wait_out(lat, 100);
        check("mr_recover_gcd", int'(bus.OUT_GCD), 3);
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
